// File: rtl/alut_mem_arbiter_pkg.sv
// Shared definitions for the ALUT table RAM arbiter: default geometry and lock FSM states.
package alut_mem_arbiter_pkg;

    localparam int ALUT_DW       = 83;
    localparam int ALUT_AW       = 8;
    localparam int ALUT_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_ADD = 2'd1,
        LOCK_AGE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alut_mem_arbiter.sv
// Single-port ALUT table arbiter: ADD has fixed priority, AGE is protected by a starvation
// counter, and a one-access lock gives either requester an atomic read-modify-write.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata/x_lock stable and holds them until
// x_gnt; the grant cycle is the RAM issue cycle, and a granted read returns x_rvalid/x_rdata on the
// following cycle. Dropping x_req before x_gnt is allowed and has no side effects.
module alut_mem_arbiter
    import alut_mem_arbiter_pkg::*;
#(
    parameter int DW       = ALUT_DW,
    parameter int AW       = ALUT_AW,
    parameter int MAX_WAIT = ALUT_MAX_WAIT
) (
    input  logic          pclk,
    input  logic          p_reset,
    input  logic          add_req,
    input  logic          add_we,
    input  logic [AW-1:0] add_addr,
    input  logic [DW-1:0] add_wdata,
    input  logic          add_lock,
    output logic          add_gnt,
    output logic          add_rvalid,
    output logic [DW-1:0] add_rdata,
    input  logic          age_req,
    input  logic          age_we,
    input  logic [AW-1:0] age_addr,
    input  logic [DW-1:0] age_wdata,
    input  logic          age_lock,
    output logic          age_gnt,
    output logic          age_rvalid,
    output logic [DW-1:0] age_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          arb_busy,
    output arb_state_t    dbg_state
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    arb_state_t    state;
    logic [3:0]    starve_cnt;
    logic [DW-1:0] add_rdata_q;
    logic [DW-1:0] age_rdata_q;
    logic          age_forced;
    logic          add_win;

    always_comb begin
        add_gnt    = 1'b0;
        age_gnt    = 1'b0;
        age_forced = age_req && (starve_cnt == MAX_W);
        add_win    = add_req && !age_forced;
        if (!p_reset) begin
            unique case (state)
                IDLE: begin
                    add_gnt = add_win;
                    age_gnt = age_req && !add_win;
                end
                LOCK_ADD: add_gnt = add_req;
                LOCK_AGE: age_gnt = age_req;
                default: begin
                    add_gnt = 1'b0;
                    age_gnt = 1'b0;
                end
            endcase
        end
    end

    assign ram_cs    = add_gnt | age_gnt;
    assign ram_we    = add_gnt ? add_we    : (age_gnt ? age_we    : 1'b0);
    assign ram_addr  = add_gnt ? add_addr  : (age_gnt ? age_addr  : '0);
    assign ram_wdata = add_gnt ? add_wdata : (age_gnt ? age_wdata : '0);

    // Return data is live on the rvalid cycle and held from the register afterwards.
    assign add_rdata = add_rvalid ? ram_rdata : add_rdata_q;
    assign age_rdata = age_rvalid ? ram_rdata : age_rdata_q;

    assign arb_busy  = (state != IDLE) | add_rvalid | age_rvalid;
    assign dbg_state = state;

    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            add_rvalid  <= 1'b0;
            age_rvalid  <= 1'b0;
            add_rdata_q <= '0;
            age_rdata_q <= '0;
        end else begin
            add_rvalid <= add_gnt & ~add_we;
            age_rvalid <= age_gnt & ~age_we;
            if (add_rvalid) add_rdata_q <= ram_rdata;
            if (age_rvalid) age_rdata_q <= ram_rdata;

            // A lock covers exactly one further access: the owner is either granted now or has
            // abandoned the lock by dropping its request, so a locked state never lasts two cycles.
            unique case (state)
                IDLE: begin
                    if (add_gnt && add_lock)      state <= LOCK_ADD;
                    else if (age_gnt && age_lock) state <= LOCK_AGE;
                end
                default: state <= IDLE;
            endcase

            if (!age_req || age_gnt)             starve_cnt <= '0;
            else if (add_gnt && starve_cnt != MAX_W) starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule
